branch_predict_unit: RTL

Parametrised branch target buffer (BTB) with 2-bit saturating direction counters and registered mispredict redirect. It sits beside fetch and decode in the MIPS pipeline. Fetch queries it with the current PC and receives a registered taken/target guess one cycle later. Decode reports each resolved control-flow instruction, and the unit trains its table and raises a one-cycle redirect on a mispredict.

---
 rtl/branch_predict_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - direct-mapped BTB with 2-bit direction counters and mispredict redirect
//
// Fetch side : f_valid/f_pc/flush in; p_valid/p_taken/p_dst out one cycle later.
// Decode side: u_valid/u_pc/u_is_branch/u_taken/u_dst/u_pred_taken/u_pred_dst in;
//              redirect_en/redirect_pc out one cycle later.
// Clock/reset: clk, resetn (asynchronous, active low).
`timescale 1ns/1ps
module branch_predict_unit #(
    parameter int         ENTRIES  = 16,
    parameter int         IDX_W    = $clog2(ENTRIES),
    parameter logic [1:0] CNT_INIT = 2'b10
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        f_valid,
    input  logic [31:0] f_pc,
    input  logic        flush,
    output logic        p_valid,
    output logic        p_taken,
    output logic [31:0] p_dst,
    input  logic        u_valid,
    input  logic [31:0] u_pc,
    input  logic        u_is_branch,
    input  logic        u_taken,
    input  logic [31:0] u_dst,
    input  logic        u_pred_taken,
    input  logic [31:0] u_pred_dst,
    output logic        redirect_en,
    output logic [31:0] redirect_pc
);
    localparam int TAG_W = 30 - IDX_W;

    // Only the valid bits need reset; tag/dst/cnt are qualified by valid.
    logic [ENTRIES-1:0] tbl_valid;
    logic [TAG_W-1:0]   tbl_tag [ENTRIES];
    logic [31:0]        tbl_dst [ENTRIES];
    logic [1:0]         tbl_cnt [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] f_tag;
    logic [TAG_W-1:0] u_tag;
    logic             f_hit;
    logic             u_hit;
    logic             f_req;
    logic             f_take;
    logic             do_alloc;
    logic             do_train;
    logic             do_inval;
    logic [1:0]       cnt_next;
    logic             mispredict;
    logic [31:0]      fix_pc;
    logic             unused_pc_bits;

    assign f_idx = f_pc[2+IDX_W-1:2];
    assign u_idx = u_pc[2+IDX_W-1:2];
    assign f_tag = f_pc[31:2+IDX_W];
    assign u_tag = u_pc[31:2+IDX_W];

    // Fetch PCs are word aligned; the low bits carry no information here.
    assign unused_pc_bits = ^f_pc[1:0];

    assign f_hit  = tbl_valid[f_idx] && (tbl_tag[f_idx] == f_tag);
    assign u_hit  = tbl_valid[u_idx] && (tbl_tag[u_idx] == u_tag);
    assign f_req  = f_valid && !flush;
    assign f_take = f_req && f_hit && tbl_cnt[f_idx][1];

    assign do_alloc = u_valid && u_is_branch && !u_hit && u_taken;
    assign do_train = u_valid && u_is_branch && u_hit;
    assign do_inval = u_valid && !u_is_branch && u_hit;

    always_comb begin
        cnt_next = tbl_cnt[u_idx];
        if (u_taken && tbl_cnt[u_idx] != 2'b11) begin
            cnt_next = tbl_cnt[u_idx] + 2'b01;
        end else if (!u_taken && tbl_cnt[u_idx] != 2'b00) begin
            cnt_next = tbl_cnt[u_idx] - 2'b01;
        end
    end

    always_comb begin
        mispredict = 1'b0;
        fix_pc     = u_pc + 32'd4;
        if (u_valid) begin
            if (u_is_branch) begin
                mispredict = (u_pred_taken != u_taken) ||
                             (u_taken && u_pred_taken && (u_pred_dst != u_dst));
                // Not-taken resumes past the delay slot.
                fix_pc     = u_taken ? u_dst : (u_pc + 32'd8);
            end else begin
                mispredict = u_pred_taken;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tbl_valid <= '0;
        end else if (do_alloc) begin
            tbl_valid[u_idx] <= 1'b1;
        end else if (do_inval) begin
            tbl_valid[u_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_alloc) begin
            tbl_tag[u_idx] <= u_tag;
            tbl_dst[u_idx] <= u_dst;
            tbl_cnt[u_idx] <= CNT_INIT;
        end else if (do_train) begin
            tbl_cnt[u_idx] <= cnt_next;
            if (u_taken) begin
                tbl_dst[u_idx] <= u_dst;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p_valid     <= 1'b0;
            p_taken     <= 1'b0;
            p_dst       <= '0;
            redirect_en <= 1'b0;
            redirect_pc <= '0;
        end else begin
            p_valid     <= f_req;
            p_taken     <= f_take;
            p_dst       <= f_take ? tbl_dst[f_idx] : 32'd0;
            redirect_en <= mispredict;
            redirect_pc <= mispredict ? fix_pc : 32'd0;
        end
    end
endmodule
